add_seq_nbit: RTL and testbench

Parametrised multi-cycle adder/subtractor and the next generation of the 4-bit ripple adder in the datapath labs. It splits WIDTH-bit operands into CHUNK-bit slices and adds one slice per clock through a single shared chunk adder, with the carry held in a register between slices. A start/done handshake lets the single-cycle and multi-cycle processor datapaths use it as a low-area ALU adder or a teaching example of serial arithmetic. Flags (carry, signed overflow, zero) are produced for branch and ALU logic.

---
 rtl/add_seq_pkg.sv | 16 +
 rtl/add_chunk.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/add_seq_nbit.sv | 145 ++++++++++++++
 tb/tb_add_seq_nbit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/add_seq_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and
// the slice-index width helper.
package add_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of the slice index: clog2(nch), never narrower than one bit.
  function automatic int idx_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit combinational ripple adder; also exposes the carry into its MSB
// so the parent can derive signed overflow on the top slice.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar g = 0; g < CHUNK; g++) begin : g_bit
    full_adder u_fa (
      .a    (a[g]),
      .b    (b[g]),
      .cin  (w_c[g]),
      .s    (sum[g]),
      .cout (w_c[g+1])
    );
  end

  assign cout  = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the chunk ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_seq_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock through
// a single shared chunk adder, with start/done handshake and ALU flags.
module add_seq_nbit
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic             iSUB,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [WIDTH-1:0] oSUM,
  output logic             oCARRY,
  output logic             oOVF,
  output logic             oZERO
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = idx_width(NCH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_busy;
  logic             r_done;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_sum_next;

  // A start is only honoured when no slices are in flight.
  assign w_accept = iSTART && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_RUN) && (r_idx == IW'(NCH - 1));

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iSTART) w_state_next = S_RUN;
        else        w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (r_idx == IW'(NCH - 1)) w_state_next = S_DONE;
        else                       w_state_next = S_RUN;
      end
      S_DONE: begin
        if (iSTART) w_state_next = S_RUN;
        else        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Slice selection and merge of the new slice into the running result.
  always_comb begin
    w_a_sl     = r_a[int'(r_idx)*CHUNK +: CHUNK];
    w_b_sl     = r_b[int'(r_idx)*CHUNK +: CHUNK];
    w_sum_next = r_sum;
    w_sum_next[int'(r_idx)*CHUNK +: CHUNK] = w_s;
  end

  add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (w_a_sl),
    .b     (w_b_sl),
    .cin   (r_c),
    .sum   (w_s),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  // Datapath, handshake and flags; B is stored pre-inverted for subtraction.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_c     <= 1'b0;
      r_idx   <= {IW{1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= iA;
      r_b    <= iB ^ {WIDTH{iSUB}};
      r_c    <= iSUB;
      r_idx  <= {IW{1'b0}};
      r_sum  <= {WIDTH{1'b0}};
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum <= w_sum_next;
      r_c   <= w_cout;
      r_idx <= r_idx + IW'(1);
      if (w_last) begin
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
        r_carry <= w_cout;
        r_ovf   <= w_cmsb ^ w_cout;
        r_zero  <= (w_sum_next == {WIDTH{1'b0}});
      end else begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign oBUSY  = r_busy;
  assign oDONE  = r_done;
  assign oSUM   = r_sum;
  assign oCARRY = r_carry;
  assign oOVF   = r_ovf;
  assign oZERO  = r_zero;

endmodule

// File: tb/tb_add_seq_nbit.sv
// Self-checking bench for add_seq_nbit (WIDTH=16, CHUNK=4): arithmetic reference
// model compared every cycle, plus directed literal checks and random traffic.
module tb_add_seq_nbit;

  localparam int W   = 16;
  localparam int NCH = 4;

  logic         iCLK = 1'b0;
  logic         iRST, iSTART, iSUB;
  logic [W-1:0] iA, iB;
  logic         oBUSY, oDONE, oCARRY, oOVF, oZERO;
  logic [W-1:0] oSUM;

  int n_chk  = 0;
  int n_fail = 0;

  add_seq_nbit #(.WIDTH(W), .CHUNK(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iSUB(iSUB), .iA(iA), .iB(iB),
    .oBUSY(oBUSY), .oDONE(oDONE), .oSUM(oSUM), .oCARRY(oCARRY), .oOVF(oOVF),
    .oZERO(oZERO)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // {ovf, carry, sum} of a op b computed with plain wide arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic [15:0] bb;
    logic [16:0] t;
    logic        ovf;
    bb  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, bb} + {16'd0, sub};
    ovf = (a[15] == bb[15]) && (t[15] != a[15]);
    return {ovf, t[16], t[15:0]};
  endfunction

  function automatic logic [15:0] slice_mask(input int n);
    logic [31:0] m;
    m = (32'd1 << (4 * n)) - 32'd1;
    return m[15:0];
  endfunction

  // Reference model: m_cnt = slices still to compute (0 means ready for a start).
  int          m_cnt;
  logic [17:0] m_res;
  logic [15:0] m_sum;
  logic        m_busy, m_done, m_c, m_o, m_z;

  always @(posedge iCLK) begin
    if (iRST) begin
      m_cnt <= 0; m_sum <= 16'd0; m_busy <= 1'b0; m_done <= 1'b0;
      m_c <= 1'b0; m_o <= 1'b0; m_z <= 1'b0; m_res <= 18'd0;
    end else if (iSTART && m_cnt == 0) begin
      m_res  <= ref_op(iA, iB, iSUB);
      m_cnt  <= NCH;
      m_sum  <= 16'd0;
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      m_sum <= m_res[15:0] & slice_mask(NCH + 1 - m_cnt);
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_c    <= m_res[16];
        m_o    <= m_res[17];
        m_z    <= (m_res[15:0] == 16'd0);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge iCLK) begin
    check("busy",  {31'd0, oBUSY},  {31'd0, m_busy});
    check("done",  {31'd0, oDONE},  {31'd0, m_done});
    check("sum",   {16'd0, oSUM},   {16'd0, m_sum});
    check("carry", {31'd0, oCARRY}, {31'd0, m_c});
    check("ovf",   {31'd0, oOVF},   {31'd0, m_o});
    check("zero",  {31'd0, oZERO},  {31'd0, m_z});
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo, input logic ez,
                        input string nm);
    int e, nb;
    @(negedge iCLK); iA = a; iB = b; iSUB = sub; iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    e = 0; nb = oBUSY ? 1 : 0;
    while (!oDONE && e < 20) begin
      @(negedge iCLK); e++;
      if (oBUSY) nb++;
    end
    check({nm, "_lat"},   e, 4);
    check({nm, "_busyn"}, nb, 4);
    check({nm, "_sum"},   {16'd0, oSUM}, {16'd0, es});
    check({nm, "_c"},     {31'd0, oCARRY}, {31'd0, ec});
    check({nm, "_o"},     {31'd0, oOVF}, {31'd0, eo});
    check({nm, "_z"},     {31'd0, oZERO}, {31'd0, ez});
    @(negedge iCLK);
    check({nm, "_donedrop"}, {31'd0, oDONE}, 32'd0);
  endtask

  initial begin
    int ndone, t, last, pulses;
    logic [15:0] dsum;
    iRST = 1'b1; iSTART = 1'b0; iSUB = 1'b0; iA = 16'd0; iB = 16'd0;
    repeat (2) @(negedge iCLK);
    check("rst_state", {26'd0, oBUSY, oDONE, oCARRY, oOVF, oZERO, 1'b0}, 32'd0);
    check("rst_sum", {16'd0, oSUM}, 32'd0);
    iRST = 1'b0;

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "t1");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "t2");
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "t3a");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "t3b");

    // Start ignored while running.
    @(negedge iCLK); iA = 16'h1234; iB = 16'h1111; iSUB = 1'b0; iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    @(negedge iCLK); iA = 16'hFFFF; iB = 16'hFFFF; iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    ndone = 0; dsum = 16'd0;
    for (int i = 0; i < 10; i++) begin
      if (oDONE) begin ndone++; dsum = oSUM; end
      @(negedge iCLK);
    end
    check("t4_ndone", ndone, 1);
    check("t4_sum", {16'd0, dsum}, 32'h2345);

    // Back-to-back with iSTART held high.
    iA = 16'h0001; iB = 16'h0001; iSUB = 1'b0; iSTART = 1'b1;
    t = 0; last = 0; pulses = 0;
    while (pulses < 4 && t < 60) begin
      @(negedge iCLK); t++;
      if (oDONE) begin
        if (pulses > 0) check("t5_gap", t - last, 5);
        if (pulses == 0) check("t5_sum0", {16'd0, oSUM}, 32'h0002);
        last = t; pulses++;
        iA = 16'(pulses * 16'h0101); iB = 16'(pulses * 16'h0011);
      end
    end
    iSTART = 1'b0;
    check("t5_pulses", pulses, 4);
    repeat (7) @(negedge iCLK);

    // Reset aborts a running operation.
    iA = 16'h00FF; iB = 16'h0001; iSUB = 1'b0; iSTART = 1'b1;
    @(negedge iCLK); iSTART = 1'b0;
    @(negedge iCLK); iRST = 1'b1;
    @(negedge iCLK);
    check("t6_flags", {27'd0, oBUSY, oDONE, oCARRY, oOVF, oZERO}, 32'd0);
    check("t6_sum", {16'd0, oSUM}, 32'd0);
    iRST = 1'b0;
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "t6b");

    // Random traffic, including stray starts and operand churn during RUN.
    for (int k = 0; k < 40; k++) begin
      @(negedge iCLK);
      iA = 16'($urandom); iB = 16'($urandom); iSUB = 1'($urandom_range(0, 1));
      if (k % 7 == 0) iB = 16'(-iA);
      iSTART = 1'b1;
      for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
        @(negedge iCLK);
        iSTART = 1'($urandom_range(0, 1));
        iA = 16'($urandom); iB = 16'($urandom); iSUB = 1'($urandom_range(0, 1));
      end
      iSTART = 1'b0;
      repeat (int'($urandom_range(0, 6))) @(negedge iCLK);
    end
    iSTART = 1'b0;
    repeat (8) @(negedge iCLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
